// File: rtl/tmds_encoder_8b10b.sv
// ============================================================================
//  Module      : tmds_encoder_8b10b
//  Description : Per-channel DVI 1.0 TMDS 8b/10b encoder. Two-stage pipeline:
//                stage 1 registers the inputs and the input popcount, stage 2
//                builds the transition-minimised word q_m, applies DC
//                balancing against the running disparity and registers the
//                10-bit symbol. dout[0] is serialized first.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmds_encoder_8b10b #(
  parameter int CNT_W = 5  // signed running-disparity width, must be >= 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       c0,
  input  logic       c1,
  input  logic       de,
  output logic [9:0] dout
);

  // Control-period symbols, indexed by {c1, c0}
  localparam logic [9:0] c_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] c_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] c_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] c_CTRL_11 = 10'b1010101011;

  // Number of ones in a byte (0..8)
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) begin
      n = n + {3'b000, v[k]};
    end
    return n;
  endfunction

  // --------------------------------------------------------------------------
  // Stage 1 registers
  // --------------------------------------------------------------------------
  logic [7:0] din_q;
  logic       c0_q;
  logic       c1_q;
  logic       de_q;
  logic [3:0] n1d_q;
  // valid_q marks a stage-1 slot that was loaded after reset; an empty slot
  // emits 10'h000 so no stale or synthetic symbol follows a reset.
  logic       valid_q;

  // Stage 1: capture pixel/control inputs and the input popcount
  always_ff @(posedge clk) begin
    if (reset) begin
      din_q   <= 8'h00;
      c0_q    <= 1'b0;
      c1_q    <= 1'b0;
      de_q    <= 1'b0;
      n1d_q   <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      din_q   <= din;
      c0_q    <= c0;
      c1_q    <= c1;
      de_q    <= de;
      n1d_q   <= popcount8(din);
      valid_q <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: transition minimisation
  // --------------------------------------------------------------------------
  logic       w_decision1;
  logic [8:0] w_qm;

  // Build q_m as an XOR or XNOR chain depending on the input ones count
  always_comb begin
    w_decision1 = (n1d_q > 4'd4) || ((n1d_q == 4'd4) && (din_q[0] == 1'b0));
    w_qm        = 9'h000;
    w_qm[0]     = din_q[0];
    for (int i = 1; i < 8; i++) begin
      w_qm[i] = w_decision1 ? ~(w_qm[i-1] ^ din_q[i]) : (w_qm[i-1] ^ din_q[i]);
    end
    w_qm[8] = ~w_decision1;
  end

  // --------------------------------------------------------------------------
  // Stage 2: DC balancing
  // --------------------------------------------------------------------------
  logic [3:0]              w_n1q;
  logic [3:0]              w_n0q;
  logic signed [CNT_W-1:0] w_n1q_s;
  logic signed [CNT_W-1:0] w_n0q_s;
  logic signed [CNT_W-1:0] w_diff_s;      // n1q - n0q
  logic signed [CNT_W-1:0] w_two_qm8;     // 2 * q_m[8]
  logic signed [CNT_W-1:0] w_two_nqm8;    // 2 * ~q_m[8]
  logic                    w_cnt_zero;
  logic                    w_cnt_neg;
  logic                    w_cnt_pos;

  logic signed [CNT_W-1:0] cnt_q;
  logic signed [CNT_W-1:0] cnt_d;
  logic [9:0]              dout_q;
  logic [9:0]              dout_d;

  assign w_n1q      = popcount8(w_qm[7:0]);
  assign w_n0q      = 4'd8 - w_n1q;
  assign w_n1q_s    = {{(CNT_W-4){1'b0}}, w_n1q};
  assign w_n0q_s    = {{(CNT_W-4){1'b0}}, w_n0q};
  assign w_diff_s   = w_n1q_s - w_n0q_s;
  assign w_two_qm8  = {{(CNT_W-2){1'b0}}, w_qm[8], 1'b0};
  assign w_two_nqm8 = {{(CNT_W-2){1'b0}}, ~w_qm[8], 1'b0};
  assign w_cnt_zero = (cnt_q == '0);
  assign w_cnt_neg  = cnt_q[CNT_W-1];
  assign w_cnt_pos  = ~w_cnt_neg & ~w_cnt_zero;

  // Select the output symbol and the updated running disparity
  always_comb begin
    dout_d = dout_q;
    cnt_d  = cnt_q;
    if (!valid_q) begin
      dout_d = 10'h000;
      cnt_d  = '0;
    end else if (!de_q) begin
      // Blanking resets disparity so every video run starts balanced
      cnt_d = '0;
      unique case ({c1_q, c0_q})
        2'b00:   dout_d = c_CTRL_00;
        2'b01:   dout_d = c_CTRL_01;
        2'b10:   dout_d = c_CTRL_10;
        default: dout_d = c_CTRL_11;
      endcase
    end else if (w_cnt_zero || (w_n1q == w_n0q)) begin
      dout_d = {~w_qm[8], w_qm[8], w_qm[8] ? w_qm[7:0] : ~w_qm[7:0]};
      cnt_d  = w_qm[8] ? (cnt_q + w_diff_s) : (cnt_q - w_diff_s);
    end else if ((w_cnt_pos && (w_n1q > w_n0q)) || (w_cnt_neg && (w_n0q > w_n1q))) begin
      // Disparity and word bias point the same way: invert the data bits
      dout_d = {1'b1, w_qm[8], ~w_qm[7:0]};
      cnt_d  = cnt_q + w_two_qm8 - w_diff_s;
    end else begin
      dout_d = {1'b0, w_qm[8], w_qm[7:0]};
      cnt_d  = cnt_q + w_diff_s - w_two_nqm8;
    end
  end

  // Stage 2 registers: output symbol and running disparity
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= 10'h000;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_tmds_encoder_8b10b.sv
// ============================================================================
//  Module      : tb_tmds_encoder_8b10b
//  Description : Self-checking bench for tmds_encoder_8b10b: a hand-computed
//                vector table followed by a long randomised video/blanking
//                run checked against a symbol-disparity reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tmds_encoder_8b10b;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       c0;
  logic       c1;
  logic       de;
  logic [9:0] dout;

  int n_tests = 0;
  int n_fail  = 0;

  tmds_encoder_8b10b #(.CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .c0    (c0),
    .c1    (c1),
    .de    (de),
    .dout  (dout)
  );

  wire signed [4:0] dut_cnt = dut.cnt_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each row: inputs applied before an edge, and dout/cnt required just after it
  typedef struct {
    logic       rst;
    logic [7:0] d;
    logic [1:0] c;    // {c1, c0}
    logic       en;
    logic [9:0] exp_dout;
    int         exp_cnt;
  } vec_t;

  vec_t tbl[24];

  task automatic apply(input logic r, input logic [7:0] d, input logic [1:0] c, input logic en);
    reset = r;
    din   = d;
    c1    = c[1];
    c0    = c[0];
    de    = en;
    @(posedge clk);
    #1;
  endtask

  task automatic check_dout(input string name, input int idx, input logic [9:0] req);
    n_tests++;
    if (dout !== req) begin
      n_fail++;
      $display("FAIL %s #%0d: dout=%h required %h", name, idx, dout, req);
    end
  endtask

  task automatic check_cnt(input string name, input int idx, input int req);
    n_tests++;
    if (int'(dut_cnt) != req) begin
      n_fail++;
      $display("FAIL %s #%0d: cnt=%0d required %0d", name, idx, int'(dut_cnt), req);
    end
  endtask

  // Reference encoder: balancing decided by signs, disparity taken from the
  // finished 10-bit symbol itself.
  task automatic ref_encode(input logic [7:0] d, input logic [1:0] c, input logic en,
                            inout int cnt, output logic [9:0] sym);
    int         ones;
    int         bal;
    logic       use_xnor;
    logic       inv;
    logic [7:0] qm;
    logic       qm8;
    if (!en) begin
      cnt = 0;
      case (c)
        2'b00:   sym = 10'h354;
        2'b01:   sym = 10'h0AB;
        2'b10:   sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
    end else begin
      ones     = $countones(d);
      use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++)
        qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm8 = ~use_xnor;
      bal = 2 * $countones(qm) - 8;
      if (cnt == 0 || bal == 0) inv = ~qm8;
      else                      inv = ((cnt > 0) == (bal > 0));
      sym = {inv, qm8, inv ? ~qm : qm};
      cnt = cnt + 2 * $countones(sym) - 10;
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++)
      o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  // Model pipeline: symbol that will appear after the next edge
  int         m_cnt      = 0;
  logic [9:0] m_next     = 10'h000;
  int         m_next_cnt = 0;
  logic       m_next_dat = 1'b0;
  logic [7:0] m_next_din = 8'h00;

  task automatic step(input logic r, input logic [7:0] d, input logic [1:0] c, input logic en, input int idx);
    logic [9:0] e_dout;
    int         e_cnt;
    logic       e_dat;
    logic [7:0] e_din;
    logic [9:0] sym;
    apply(r, d, c, en);
    if (r) begin
      e_dout = 10'h000; e_cnt = 0; e_dat = 1'b0; e_din = 8'h00;
    end else begin
      e_dout = m_next; e_cnt = m_next_cnt; e_dat = m_next_dat; e_din = m_next_din;
    end
    check_dout("model_dout", idx, e_dout);
    check_cnt("model_cnt", idx, e_cnt);
    n_tests++;
    if (int'(dut_cnt) > 10 || int'(dut_cnt) < -10) begin
      n_fail++;
      $display("FAIL cnt_bound #%0d: cnt=%0d required |cnt|<=10", idx, int'(dut_cnt));
    end
    if (e_dat) begin
      n_tests++;
      if (decode(dout) !== e_din) begin
        n_fail++;
        $display("FAIL decode #%0d: decoded=%h required %h", idx, decode(dout), e_din);
      end
    end
    if (r) begin
      m_cnt = 0; m_next = 10'h000; m_next_cnt = 0; m_next_dat = 1'b0; m_next_din = 8'h00;
    end else begin
      ref_encode(d, c, en, m_cnt, sym);
      m_next = sym; m_next_cnt = m_cnt; m_next_dat = en; m_next_din = d;
    end
  endtask

  initial begin
    int cyc;
    int data_cnt;
    int run;
    reset = 1'b1; din = 8'h00; c0 = 1'b0; c1 = 1'b0; de = 1'b0;

    //           rst   din     c1c0   de    dout     cnt
    tbl[0]  = '{1'b1, 8'h00, 2'b00, 1'b0, 10'h000,  0};
    tbl[1]  = '{1'b1, 8'h00, 2'b00, 1'b0, 10'h000,  0};
    tbl[2]  = '{1'b0, 8'h00, 2'b00, 1'b0, 10'h000,  0};
    tbl[3]  = '{1'b0, 8'h00, 2'b01, 1'b0, 10'h354,  0};
    tbl[4]  = '{1'b0, 8'h00, 2'b10, 1'b0, 10'h0AB,  0};
    tbl[5]  = '{1'b0, 8'h00, 2'b11, 1'b0, 10'h154,  0};
    tbl[6]  = '{1'b0, 8'h00, 2'b00, 1'b1, 10'h2AB,  0};
    tbl[7]  = '{1'b0, 8'h00, 2'b00, 1'b1, 10'h100, -8};
    tbl[8]  = '{1'b0, 8'h00, 2'b11, 1'b1, 10'h3FF,  2};
    tbl[9]  = '{1'b0, 8'h5A, 2'b00, 1'b0, 10'h100, -6};
    tbl[10] = '{1'b0, 8'hFF, 2'b00, 1'b1, 10'h354,  0};
    tbl[11] = '{1'b0, 8'hFF, 2'b00, 1'b1, 10'h200, -8};
    tbl[12] = '{1'b0, 8'h00, 2'b00, 1'b0, 10'h0FF, -2};
    tbl[13] = '{1'b0, 8'h00, 2'b00, 1'b0, 10'h354,  0};
    tbl[14] = '{1'b0, 8'h10, 2'b00, 1'b1, 10'h354,  0};
    tbl[15] = '{1'b0, 8'h00, 2'b00, 1'b0, 10'h1F0,  0};
    tbl[16] = '{1'b0, 8'h00, 2'b00, 1'b0, 10'h354,  0};
    tbl[17] = '{1'b0, 8'h00, 2'b00, 1'b1, 10'h354,  0};
    tbl[18] = '{1'b0, 8'h00, 2'b00, 1'b1, 10'h100, -8};
    tbl[19] = '{1'b1, 8'h00, 2'b00, 1'b1, 10'h000,  0};
    tbl[20] = '{1'b0, 8'h00, 2'b00, 1'b1, 10'h000,  0};
    tbl[21] = '{1'b0, 8'h00, 2'b00, 1'b1, 10'h100, -8};
    tbl[22] = '{1'b0, 8'h00, 2'b00, 1'b0, 10'h3FF,  2};
    tbl[23] = '{1'b0, 8'h00, 2'b00, 1'b0, 10'h354,  0};

    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].rst, tbl[i].d, tbl[i].c, tbl[i].en);
      check_dout("vec_dout", i, tbl[i].exp_dout);
      check_cnt("vec_cnt", i, tbl[i].exp_cnt);
    end

    // Randomised video lines with blanking, one reset dropped mid-line
    step(1'b1, 8'h00, 2'b00, 1'b0, 0);
    step(1'b1, 8'h00, 2'b00, 1'b0, 1);
    cyc = 2;
    data_cnt = 0;
    while (data_cnt < 2000) begin
      run = $urandom_range(1, 40);
      for (int k = 0; k < run; k++) begin
        step((data_cnt == 1000) ? 1'b1 : 1'b0, 8'($urandom), 2'($urandom), 1'b1, cyc);
        cyc++;
        data_cnt++;
      end
      run = $urandom_range(1, 8);
      for (int k = 0; k < run; k++) begin
        step(1'b0, 8'($urandom), 2'($urandom), 1'b0, cyc);
        cyc++;
      end
    end
    // Drain the pipeline
    step(1'b0, 8'h00, 2'b00, 1'b0, cyc);
    step(1'b0, 8'h00, 2'b00, 1'b0, cyc + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
